shift_transmitter: RTL and testbench

Parametrised serializer that loads a parallel word through a valid/ready handshake and shifts it out one bit per enabled cycle, MSB- or LSB-first, for a programmable length of 1..WIDTH bits. It drives the TDO-side data path of the JTAG test-data registers and replaces the fixed 32-bit, MSB-only byte transmitter. New behaviour over that block: pause on `enable` low, variable length, bit order selection, abort, and an explicit load handshake.

---
 rtl/jtag_pkg.sv | 12 +
 rtl/shift_transmitter.sv | 124 ++++++++++++
 tb/tb_shift_transmitter.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/jtag_pkg.sv
// Shared definitions for the JTAG test-data register blocks.
// Default DR width and the serializer state encoding.
package jtag_pkg;

    localparam int DR_WIDTH = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } tx_state_t;

endpackage

// File: rtl/shift_transmitter.sv
// TDO-side serializer: loads a word via valid/ready and shifts it out
// one bit per enabled cycle, MSB- or LSB-first, for 1..WIDTH bits.
module shift_transmitter
    import jtag_pkg::*;
#(
    parameter int WIDTH     = DR_WIDTH,
    parameter int LSB_FIRST = 0,
    parameter int CNT_W     = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in,
    input  logic [CNT_W-1:0] len,
    input  logic             enable,
    input  logic             abort,
    output logic             out,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(WIDTH);

    tx_state_t        state;
    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] eff_len;
    logic             head;
    logic [WIDTH-1:0] shreg_next;

    assign in_ready = (state == IDLE);
    assign busy     = (state == SHIFT);

    // Length seen by the counter: 0 and oversize requests mean a full word.
    always_comb begin
        eff_len = len;
        if (len == '0 || len > MAX_LEN) begin
            eff_len = MAX_LEN;
        end
    end

    // Head bit and the zero-filled shift toward it, for the chosen order.
    always_comb begin
        if (LSB_FIRST != 0) begin
            head       = shreg[0];
            shreg_next = {1'b0, shreg[WIDTH-1:1]};
        end else begin
            head       = shreg[WIDTH-1];
            shreg_next = {shreg[WIDTH-2:0], 1'b0};
        end
    end

    // FSM, bit counter and shift register; abort outranks everything else.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
            out   <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state <= IDLE;
                shreg <= '0;
                cnt   <= '0;
                out   <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        out <= 1'b0;
                        if (in_valid) begin
                            shreg <= in;
                            cnt   <= eff_len;
                            state <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        if (enable) begin
                            out   <= head;
                            shreg <= shreg_next;
                            if (cnt <= CNT_W'(1)) begin
                                cnt   <= '0;
                                done  <= 1'b1;
                                state <= IDLE;
                            end else begin
                                cnt <= cnt - CNT_W'(1);
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef FORMAL
    logic [CNT_W-1:0] f_len;
    logic [CNT_W-1:0] f_seen;

    // Track loaded length and enabled shift edges of the current word.
    always_ff @(posedge clk) begin
        if (reset || abort) begin
            f_len  <= '0;
            f_seen <= '0;
        end else if (state == IDLE && in_valid) begin
            f_len  <= eff_len;
            f_seen <= '0;
        end else if (state == SHIFT && enable) begin
            f_seen <= f_seen + CNT_W'(1);
        end
    end

    a_cnt_max : assert property (@(posedge clk) cnt <= MAX_LEN);

    a_done_src : assert property (@(posedge clk) disable iff (reset)
        done |-> $past(state == SHIFT && cnt == CNT_W'(1)));

    a_len_match : assert property (@(posedge clk) disable iff (reset)
        done |-> f_seen == f_len);
`endif

endmodule

// File: tb/tb_shift_transmitter.sv
// Scoreboard bench for shift_transmitter: one MSB-first and one
// LSB-first instance, expected bits queued at load, checked per edge.
module tb_shift_transmitter;

    localparam int W  = 32;
    localparam int CW = $clog2(W + 1);

    typedef struct packed {
        logic o;
        logic d;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid_m, in_valid_l;
    logic          in_ready_m, in_ready_l;
    logic [W-1:0]  in;
    logic [CW-1:0] len;
    logic          enable;
    logic          abort;
    logic          out_m, out_l;
    logic          busy_m, busy_l;
    logic          done_m, done_l;

    int   checks   = 0;
    int   failures = 0;
    exp_t qm[$];
    exp_t ql[$];
    logic sh_m = 1'b0;
    logic sh_l = 1'b0;

    always #5 clk = ~clk;

    shift_transmitter #(.WIDTH(W), .LSB_FIRST(0)) dut_m (
        .clk(clk), .reset(reset), .in_valid(in_valid_m),
        .in_ready(in_ready_m), .in(in), .len(len),
        .enable(enable), .abort(abort), .out(out_m),
        .busy(busy_m), .done(done_m)
    );

    shift_transmitter #(.WIDTH(W), .LSB_FIRST(1)) dut_l (
        .clk(clk), .reset(reset), .in_valid(in_valid_l),
        .in_ready(in_ready_l), .in(in), .len(len),
        .enable(enable), .abort(abort), .out(out_l),
        .busy(busy_l), .done(done_l)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Flag edges at which a DUT should present a new serial bit.
    always @(posedge clk) begin
        sh_m <= busy_m && enable && !abort && !reset;
        sh_l <= busy_l && enable && !abort && !reset;
    end

    // Monitor for the MSB-first instance.
    always @(negedge clk) begin
        exp_t e;
        if (sh_m) begin
            if (qm.size() == 0) begin
                chk("msb_unexpected_bit", 32'(1), 32'(0));
            end else begin
                e = qm.pop_front();
                chk("msb_out", 32'(out_m), 32'(e.o));
                chk("msb_done", 32'(done_m), 32'(e.d));
            end
        end else begin
            chk("msb_done_idle", 32'(done_m), 32'(0));
        end
    end

    // Monitor for the LSB-first instance.
    always @(negedge clk) begin
        exp_t e;
        if (sh_l) begin
            if (ql.size() == 0) begin
                chk("lsb_unexpected_bit", 32'(1), 32'(0));
            end else begin
                e = ql.pop_front();
                chk("lsb_out", 32'(out_l), 32'(e.o));
                chk("lsb_done", 32'(done_l), 32'(e.d));
            end
        end else begin
            chk("lsb_done_idle", 32'(done_l), 32'(0));
        end
    end

    // Queue the first n bits of a word; done flagged on the last if fin.
    task automatic push(input bit lsb, input logic [31:0] w,
                        input int n, input bit fin);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.o = lsb ? w[i] : w[31-i];
            e.d = fin && (i == n - 1);
            if (lsb) ql.push_back(e);
            else     qm.push_back(e);
        end
    endtask

    task automatic load(input bit lsb, input logic [31:0] w,
                        input logic [CW-1:0] l);
        int k;
        k = 0;
        while (k < 50 && !(lsb ? in_ready_l : in_ready_m)) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) chk("ready_timeout", 32'(1), 32'(0));
        in  = w;
        len = l;
        if (lsb) in_valid_l = 1'b1;
        else     in_valid_m = 1'b1;
        @(negedge clk);
        in_valid_l = 1'b0;
        in_valid_m = 1'b0;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        logic [5:0] pat;
        reset      = 1'b1;
        in_valid_m = 1'b0;
        in_valid_l = 1'b0;
        in         = '0;
        len        = '0;
        enable     = 1'b0;
        abort      = 1'b0;
        cycles(3);
        reset = 1'b0;
        @(negedge clk);

        chk("rst_out", 32'(out_m), 32'(0));
        chk("rst_busy", 32'(busy_m), 32'(0));
        chk("rst_ready", 32'(in_ready_m), 32'(1));
        chk("rst_ready_l", 32'(in_ready_l), 32'(1));

        // Full-width MSB-first, len=0 means 32 bits.
        enable = 1'b1;
        push(0, 32'hA5A5_0F0F, 32, 1);
        load(0, 32'hA5A5_0F0F, 6'd0);
        cycles(32);
        chk("full_done_last", 32'(done_m), 32'(1));
        @(negedge clk);
        chk("full_out_idle", 32'(out_m), 32'(0));
        chk("full_busy_idle", 32'(busy_m), 32'(0));

        // Short LSB-first word.
        push(1, 32'h0000_00B4, 8, 1);
        load(1, 32'h0000_00B4, 6'd8);
        cycles(8);
        chk("lsb_done8", 32'(done_l), 32'(1));
        chk("lsb_ready8", 32'(in_ready_l), 32'(1));
        @(negedge clk);

        // Pause: enable pattern 1,0,0,1,1,1 across a 4-bit word.
        enable = 1'b0;
        push(0, 32'hF000_0000, 4, 1);
        load(0, 32'hF000_0000, 6'd4);
        pat = 6'b111001;
        for (int i = 0; i < 6; i++) begin
            enable = pat[i];
            @(negedge clk);
            if (i == 1 || i == 2) begin
                chk("pause_hold_out", 32'(out_m), 32'(1));
                chk("pause_busy", 32'(busy_m), 32'(1));
            end
        end
        chk("pause_done6", 32'(done_m), 32'(1));
        @(negedge clk);

        // Abort after 10 of 32 bits.
        enable = 1'b1;
        push(0, 32'hA5A5_0F0F, 10, 0);
        load(0, 32'hA5A5_0F0F, 6'd0);
        cycles(10);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 32'(busy_m), 32'(0));
        chk("abort_out", 32'(out_m), 32'(0));
        chk("abort_ready", 32'(in_ready_m), 32'(1));

        // Abort outranks a load request in IDLE.
        in_valid_m = 1'b1;
        abort      = 1'b1;
        @(negedge clk);
        in_valid_m = 1'b0;
        abort      = 1'b0;
        chk("abort_vs_load", 32'(busy_m), 32'(0));

        // Reload after abort: LSB-first 3 bits of 0x5 -> 1,0,1.
        push(1, 32'h0000_0005, 3, 1);
        load(1, 32'h0000_0005, 6'd3);
        cycles(4);
        chk("abort_reload_idle", 32'(busy_l), 32'(0));

        // Reset after 5 bits, then oversize length is clamped.
        push(0, 32'hDEAD_BEEF, 5, 0);
        load(0, 32'hDEAD_BEEF, 6'd0);
        cycles(5);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst2_out", 32'(out_m), 32'(0));
        chk("rst2_busy", 32'(busy_m), 32'(0));
        chk("rst2_done", 32'(done_m), 32'(0));
        chk("rst2_ready", 32'(in_ready_m), 32'(1));
        push(0, 32'h1234_5678, 32, 1);
        load(0, 32'h1234_5678, 6'd40);
        cycles(32);
        chk("clamp_done32", 32'(done_m), 32'(1));
        @(negedge clk);
        chk("clamp_idle", 32'(busy_m), 32'(0));

        // Back-to-back with in_valid held high.
        push(0, 32'h8000_0001, 32, 1);
        push(0, 32'h7FFF_FFFE, 32, 1);
        in         = 32'h8000_0001;
        len        = '0;
        in_valid_m = 1'b1;
        @(negedge clk);
        in = 32'h7FFF_FFFE;
        cycles(33);
        chk("b2b_gap_out", 32'(out_m), 32'(0));
        chk("b2b_gap_busy", 32'(busy_m), 32'(1));
        in_valid_m = 1'b0;
        cycles(33);
        chk("b2b_idle", 32'(busy_m), 32'(0));

        cycles(2);
        chk("qm_drained", 32'(qm.size()), 32'(0));
        chk("ql_drained", 32'(ql.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
